// File: rtl/pdp_mem_arbiter.sv
// Round-robin arbiter giving NUM_CH requesters access to one single-ported memory
// with a pipelined read return. Optional watchdog enabled by PDP_MEM_ARB_STARVE_CHK_EN.
module pdp_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic [NUM_CH-1:0]            ch_rvalid,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]            starve_err
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      last_gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic [IDX_W-1:0]      cand;
    logic                  gnt_any;
    logic                  gnt_vld;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [RD_LATENCY-1:0] pv;
    logic [IDX_W-1:0]      pc [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pd [RD_LATENCY];

    // Round-robin search starting one past the last winner; grant is forced low in reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last_gnt;
        cand    = '0;
        ch_gnt  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((32'(last_gnt) + k) % NUM_CH);
            if (!gnt_any && ch_req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vld = gnt_any && reset_n;
        if (gnt_vld) begin
            ch_gnt[gnt_idx] = 1'b1;
        end
    end

    assign sel_we    = ch_we[gnt_idx];
    assign sel_addr  = ch_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = ch_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // Backing store: contents survive reset.
    always_ff @(posedge clk) begin
        if (gnt_vld && sel_we) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Pointer and read-return pipeline; stage data only moves with a valid so the
    // last stage doubles as the held read-data bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= IDX_W'(NUM_CH - 1);
            pv       <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pc[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            if (gnt_vld) begin
                last_gnt <= gnt_idx;
            end
            pv[0] <= gnt_vld && !sel_we;
            if (gnt_vld && !sel_we) begin
                pc[0] <= gnt_idx;
                pd[0] <= mem[sel_addr];
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pc[i] <= pc[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    always_comb begin
        ch_rvalid = '0;
        if (pv[RD_LATENCY-1]) begin
            ch_rvalid[pc[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign ch_rdata = pd[RD_LATENCY-1];

`ifdef PDP_MEM_ARB_STARVE_CHK_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt [NUM_CH];

    // Saturating per-channel wait counters with sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_err <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_req[i] && !ch_gnt[i]) begin
                    if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                        wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    end
                    if (wait_cnt[i] == CNT_W'(STARVE_LIMIT - 1)) begin
                        starve_err[i] <= 1'b1;
                        if (!starve_err[i]) begin
                            $error("pdp_mem_arbiter: channel %0d starved", i);
                        end
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign starve_err = '0;
`endif

endmodule
